// File: rtl/fcs_frame_sequencer.sv
// fcs_frame_sequencer
// Frame-level controller for an external 32-bit crc32 engine. Full beats are
// folded by the engine in one cycle; the bytes of a partial last beat are
// folded one per cycle by an internal byte-wise CRC step. The final FCS and
// frame byte length are presented with a one-cycle result strobe.
module fcs_frame_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int CRC_WIDTH  = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   o_crc_data,
   output logic [CRC_WIDTH-1:0]    o_crc_state,
   output logic                    o_crc_en,
   input  logic [CRC_WIDTH-1:0]    i_crc_next,
   output logic [CRC_WIDTH-1:0]    o_fcs,
   output logic [LEN_WIDTH-1:0]    o_frame_len,
   output logic                    o_fcs_valid,
   output logic                    o_fcs_err,
   output logic                    o_busy
);

   localparam logic [CRC_WIDTH-1:0] CRC_INIT = {CRC_WIDTH{1'b1}};
   localparam logic [CRC_WIDTH-1:0] CRC_POLY = 32'hEDB8_8320;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_TAIL = 2'd2
   } state_t;

   // One reflected CRC-32 byte step (LSB first), used for partial tail bytes.
   function automatic logic [CRC_WIDTH-1:0] crc_fold_byte(
      input logic [CRC_WIDTH-1:0] crc,
      input logic [7:0]           b
   );
      logic [CRC_WIDTH-1:0] c;
      c = crc ^ {{(CRC_WIDTH-8){1'b0}}, b};
      for (int i = 0; i < 8; i++) begin
         if (c[0]) begin
            c = (c >> 1) ^ CRC_POLY;
         end else begin
            c = c >> 1;
         end
      end
      return c;
   endfunction

   // Length add that sticks at all-ones instead of wrapping.
   function automatic logic [LEN_WIDTH-1:0] len_sat_add(
      input logic [LEN_WIDTH-1:0] len,
      input logic [2:0]           inc
   );
      logic [LEN_WIDTH:0] sum;
      sum = {1'b0, len} + {{(LEN_WIDTH-2){1'b0}}, inc};
      if (sum[LEN_WIDTH]) begin
         return {LEN_WIDTH{1'b1}};
      end else begin
         return sum[LEN_WIDTH-1:0];
      end
   endfunction

   state_t                  state_q, state_d;
   logic [CRC_WIDTH-1:0]    crc_q, crc_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   tail_data_q, tail_data_d;
   logic [1:0]              tail_cnt_q, tail_cnt_d;
   logic [CRC_WIDTH-1:0]    fcs_q, fcs_d;
   logic [LEN_WIDTH-1:0]    flen_q, flen_d;
   logic                    fval_q, fval_d;
   logic                    ferr_q, ferr_d;
   logic                    ready_q;
   logic                    busy_q;

   logic                    accept_s;
   logic                    keep_full_s;
   logic                    keep_part_s;
   logic [1:0]              keep_cnt_s;
   logic                    crc_en_s;
   logic [CRC_WIDTH-1:0]    tail_fold_s;
   logic                    res_s;
   logic [CRC_WIDTH-1:0]    res_fcs_s;
   logic [LEN_WIDTH-1:0]    res_len_s;
   logic                    res_err_s;

   // Beat acceptance and tkeep classification of the current beat.
   always_comb begin
      accept_s    = s_axis_tvalid & ready_q & i_reset_n;
      keep_full_s = (s_axis_tkeep == 4'hF);
      keep_part_s = 1'b1;
      keep_cnt_s  = 2'd0;
      case (s_axis_tkeep)
         4'h1:    keep_cnt_s  = 2'd1;
         4'h3:    keep_cnt_s  = 2'd2;
         4'h7:    keep_cnt_s  = 2'd3;
         default: keep_part_s = 1'b0;
      endcase
   end

   // FSM state register.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (accept_s) begin
               if (!s_axis_tlast) begin
                  state_d = ST_RUN;
               end else if (keep_part_s) begin
                  state_d = ST_TAIL;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_TAIL: begin
            if (tail_cnt_q == 2'd1) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_TAIL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and datapath next values (engine enable, CRC, length, results).
   always_comb begin
      crc_en_s    = 1'b0;
      crc_d       = crc_q;
      len_d       = len_q;
      err_d       = err_q;
      tail_data_d = tail_data_q;
      tail_cnt_d  = tail_cnt_q;
      res_s       = 1'b0;
      res_fcs_s   = ~crc_q;
      res_len_s   = len_q;
      res_err_s   = err_q;
      tail_fold_s = crc_fold_byte(crc_q, tail_data_q[7:0]);
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (accept_s) begin
               if (!s_axis_tlast) begin
                  // Mid-frame beats always carry 4 bytes; a bad tkeep is only flagged.
                  crc_en_s = 1'b1;
                  crc_d    = i_crc_next;
                  len_d    = len_sat_add(len_q, 3'd4);
                  if (!keep_full_s) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = err_q;
                  end
               end else if (keep_full_s) begin
                  crc_en_s  = 1'b1;
                  res_s     = 1'b1;
                  res_fcs_s = ~i_crc_next;
                  res_len_s = len_sat_add(len_q, 3'd4);
               end else if (s_axis_tkeep == 4'h0) begin
                  res_s = 1'b1;
               end else if (keep_part_s) begin
                  tail_data_d = s_axis_tdata;
                  tail_cnt_d  = keep_cnt_s;
                  len_d       = len_sat_add(len_q, {1'b0, keep_cnt_s});
               end else begin
                  // Non-contiguous last beat: report with error, CRC untouched.
                  res_s     = 1'b1;
                  res_err_s = 1'b1;
               end
            end else begin
               crc_en_s = 1'b0;
            end
         end
         ST_TAIL: begin
            crc_d       = tail_fold_s;
            tail_data_d = tail_data_q >> 8;
            tail_cnt_d  = tail_cnt_q - 2'd1;
            if (tail_cnt_q == 2'd1) begin
               res_s     = 1'b1;
               res_fcs_s = ~tail_fold_s;
            end else begin
               res_s = 1'b0;
            end
         end
         default: begin
            crc_d = CRC_INIT;
         end
      endcase

      if (res_s) begin
         fcs_d  = res_fcs_s;
         flen_d = res_len_s;
         fval_d = 1'b1;
         ferr_d = res_err_s;
         crc_d  = CRC_INIT;
         len_d  = {LEN_WIDTH{1'b0}};
         err_d  = 1'b0;
      end else begin
         fcs_d  = fcs_q;
         flen_d = flen_q;
         fval_d = 1'b0;
         ferr_d = ferr_q;
      end
   end

   // Datapath and result registers; results hold until the next strobe.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         crc_q       <= CRC_INIT;
         len_q       <= {LEN_WIDTH{1'b0}};
         err_q       <= 1'b0;
         tail_data_q <= {DATA_WIDTH{1'b0}};
         tail_cnt_q  <= 2'd0;
         fcs_q       <= {CRC_WIDTH{1'b0}};
         flen_q      <= {LEN_WIDTH{1'b0}};
         fval_q      <= 1'b0;
         ferr_q      <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         crc_q       <= crc_d;
         len_q       <= len_d;
         err_q       <= err_d;
         tail_data_q <= tail_data_d;
         tail_cnt_q  <= tail_cnt_d;
         fcs_q       <= fcs_d;
         flen_q      <= flen_d;
         fval_q      <= fval_d;
         ferr_q      <= ferr_d;
         ready_q     <= (state_d != ST_TAIL);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign s_axis_tready = ready_q;
   assign o_crc_data    = s_axis_tdata;
   assign o_crc_state   = crc_q;
   assign o_crc_en      = crc_en_s;
   assign o_fcs         = fcs_q;
   assign o_frame_len   = flen_q;
   assign o_fcs_valid   = fval_q;
   assign o_fcs_err     = ferr_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_fcs_frame_sequencer.sv
// Directed bench for fcs_frame_sequencer. A behavioural 32-bit crc32 engine
// closes the loop; expected FCS values come from a byte-wise software CRC-32.
module tb_fcs_frame_sequencer;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tkeep;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [31:0] o_crc_data;
   logic [31:0] o_crc_state;
   logic        o_crc_en;
   logic [31:0] i_crc_next;
   logic [31:0] o_fcs;
   logic [15:0] o_frame_len;
   logic        o_fcs_valid;
   logic        o_fcs_err;
   logic        o_busy;

   fcs_frame_sequencer dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .o_crc_data    (o_crc_data),
      .o_crc_state   (o_crc_state),
      .o_crc_en      (o_crc_en),
      .i_crc_next    (i_crc_next),
      .o_fcs         (o_fcs),
      .o_frame_len   (o_frame_len),
      .o_fcs_valid   (o_fcs_valid),
      .o_fcs_err     (o_fcs_err),
      .o_busy        (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Behavioural crc32 engine: one 32-bit reflected step.
   function automatic logic [31:0] eng_step(input logic [31:0] st, input logic [31:0] d);
      logic [31:0] c;
      c = st ^ d;
      for (int i = 0; i < 32; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction
   assign i_crc_next = eng_step(o_crc_state, o_crc_data);

   typedef struct {
      logic [31:0] fcs;
      logic [15:0] len;
      logic        err;
      int          cyc;
   } res_t;

   res_t        res_q[$];
   logic [7:0]  fb[$];
   int          cyc = 0;
   int          acc_cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          ready_drops = 0;
   bit          ready_mon = 1'b0;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_fcs_valid === 1'b1) res_q.push_back('{o_fcs, o_frame_len, o_fcs_err, cyc});
      if (ready_mon && s_axis_tready !== 1'b1) ready_drops++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Software CRC-32 of the bytes in fb, final value inverted.
   function automatic logic [31:0] sw_crc();
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (fb[i]) begin
         c = c ^ {24'd0, fb[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      int w = 0;
      while (s_axis_tready !== 1'b1 && w < 100) begin
         @(posedge i_clk); #1;
         w++;
      end
      if (w >= 100) chk("ready_timeout", 32'(s_axis_tready), 32'd1);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      @(posedge i_clk); #1;
      acc_cyc       = cyc;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tkeep  = 4'h0;
      s_axis_tdata  = $urandom;
   endtask

   task automatic send_fb(input bit gaps);
      int nb;
      int i;
      int cnt;
      logic [31:0] d;
      logic [3:0]  k;
      nb = fb.size();
      i  = 0;
      do begin
         d   = 32'd0;
         k   = 4'h0;
         cnt = (nb - i >= 4) ? 4 : nb - i;
         for (int j = 0; j < cnt; j++) begin
            d[j*8 +: 8] = fb[i+j];
            k[j]        = 1'b1;
         end
         i += cnt;
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(posedge i_clk); #1;
            end
         end
         drive_beat(d, k, (i >= nb));
      end while (i < nb);
   endtask

   task automatic expect_res(input string tag, input logic [31:0] ef, input logic [15:0] el,
                             input logic ee, input int elat, input int acc, input bit chk_len,
                             output int rc);
      res_t r;
      int   w = 0;
      rc = 0;
      while (res_q.size() == 0 && w < 300) begin
         @(posedge i_clk); #1;
         w++;
      end
      chk({tag, "/present"}, 32'(res_q.size() != 0), 32'd1);
      if (res_q.size() != 0) begin
         r  = res_q.pop_front();
         rc = r.cyc;
         chk({tag, "/fcs"}, r.fcs, ef);
         if (chk_len) chk({tag, "/len"}, 32'(r.len), 32'(el));
         chk({tag, "/err"}, 32'(r.err), 32'(ee));
         if (elat >= 0) chk({tag, "/latency"}, 32'(r.cyc - acc), 32'(elat));
      end
   endtask

   task automatic load_123456789();
      fb.delete();
      for (int i = 0; i < 9; i++) fb.push_back(8'h31 + 8'(i));
   endtask

   initial begin
      int rc_a;
      int rc_b;
      int acc_a;
      int n;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] w0;

      i_reset_n     = 1'b0;
      s_axis_tdata  = 32'hA5A5_5A5A;
      s_axis_tkeep  = 4'h0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;

      // Reset values
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst/tready", 32'(s_axis_tready), 32'd0);
      chk("rst/crc_en", 32'(o_crc_en), 32'd0);
      chk("rst/crc_state", o_crc_state, 32'hFFFF_FFFF);
      chk("rst/crc_data", o_crc_data, 32'hA5A5_5A5A);
      chk("rst/fcs", o_fcs, 32'd0);
      chk("rst/len", 32'(o_frame_len), 32'd0);
      chk("rst/valid", 32'(o_fcs_valid), 32'd0);
      chk("rst/err", 32'(o_fcs_err), 32'd0);
      chk("rst/busy", 32'(o_busy), 32'd0);
      i_reset_n = 1'b1;
      @(posedge i_clk); #1;
      chk("post_rst/tready", 32'(s_axis_tready), 32'd1);

      // "123456789" with a 1-byte tail
      load_123456789();
      send_fb(1'b0);
      chk("crc9/tready_low", 32'(s_axis_tready), 32'd0);
      chk("crc9/busy_tail", 32'(o_busy), 32'd1);
      chk("crc9/valid_early", 32'(o_fcs_valid), 32'd0);
      @(posedge i_clk); #1;
      chk("crc9/valid", 32'(o_fcs_valid), 32'd1);
      chk("crc9/tready_back", 32'(s_axis_tready), 32'd1);
      chk("crc9/fcs_direct", o_fcs, 32'hCBF4_3926);
      @(posedge i_clk); #1;
      chk("crc9/valid_once", 32'(o_fcs_valid), 32'd0);
      chk("crc9/fcs_hold", o_fcs, 32'hCBF4_3926);
      expect_res("crc9", 32'hCBF4_3926, 16'd9, 1'b0, 1, acc_cyc, 1'b1, rc_a);

      // Zero-byte frame
      fb.delete();
      send_fb(1'b0);
      chk("zero/valid", 32'(o_fcs_valid), 32'd1);
      expect_res("zero", 32'h0000_0000, 16'd0, 1'b0, 0, acc_cyc, 1'b1, rc_a);

      // Back-to-back 64-byte frames, tvalid continuous
      ready_mon = 1'b1;
      fb.delete();
      for (int i = 0; i < 64; i++) fb.push_back(8'($urandom));
      exp_a = sw_crc();
      send_fb(1'b0);
      acc_a = acc_cyc;
      fb.delete();
      for (int i = 0; i < 64; i++) fb.push_back(8'($urandom));
      exp_b = sw_crc();
      send_fb(1'b0);
      ready_mon = 1'b0;
      chk("b2b/ready_drops", 32'(ready_drops), 32'd0);
      expect_res("b2b_a", exp_a, 16'd64, 1'b0, 0, acc_a, 1'b1, rc_a);
      expect_res("b2b_b", exp_b, 16'd64, 1'b0, 0, acc_cyc, 1'b1, rc_b);
      chk("b2b/spacing", 32'(rc_b - rc_a), 32'd16);

      // Random-length frames with tvalid gaps
      for (int f = 0; f < 5; f++) begin
         n = (f == 0) ? 1 : $urandom_range(1, 1518);
         fb.delete();
         for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
         exp_a = sw_crc();
         send_fb(1'b1);
         expect_res($sformatf("rand%0d", f), exp_a, 16'(n), 1'b0, n % 4, acc_cyc, 1'b1, rc_a);
      end

      // Non-contiguous last tkeep, then a clean frame
      w0 = $urandom;
      fb.delete();
      for (int j = 0; j < 4; j++) fb.push_back(w0[j*8 +: 8]);
      exp_a = sw_crc();
      drive_beat(w0, 4'hF, 1'b0);
      drive_beat(32'hDEAD_BEEF, 4'hA, 1'b1);
      expect_res("keepA", exp_a, 16'd0, 1'b1, 0, acc_cyc, 1'b0, rc_a);
      load_123456789();
      send_fb(1'b0);
      expect_res("keepA_clean", 32'hCBF4_3926, 16'd9, 1'b0, 1, acc_cyc, 1'b1, rc_a);

      // Sticky error from a bad mid-frame tkeep; all 4 bytes still folded
      w0 = 32'h0403_0201;
      fb.delete();
      for (int j = 0; j < 8; j++) fb.push_back(8'(j + 1));
      exp_a = sw_crc();
      drive_beat(w0, 4'h3, 1'b0);
      drive_beat(32'h0807_0605, 4'hF, 1'b1);
      expect_res("sticky", exp_a, 16'd8, 1'b1, 0, acc_cyc, 1'b1, rc_a);

      // Reset during a 3-byte tail
      fb.delete();
      for (int i = 0; i < 7; i++) fb.push_back(8'($urandom));
      send_fb(1'b0);
      i_reset_n = 1'b0;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      chk("tailrst/crc_state", o_crc_state, 32'hFFFF_FFFF);
      repeat (6) begin
         @(posedge i_clk); #1;
      end
      chk("tailrst/no_valid", 32'(res_q.size()), 32'd0);
      load_123456789();
      send_fb(1'b0);
      expect_res("tailrst_clean", 32'hCBF4_3926, 16'd9, 1'b0, 1, acc_cyc, 1'b1, rc_a);

      // Length saturation at 16'hFFFF (65540 bytes)
      fb.delete();
      for (int i = 0; i < 65540; i++) fb.push_back(8'(i));
      exp_a = sw_crc();
      send_fb(1'b0);
      expect_res("sat", exp_a, 16'hFFFF, 1'b0, 0, acc_cyc, 1'b1, rc_a);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
